// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, optional parity, 1-2 stop bits)
// with 3-sample majority voting, error flags and a valid/ready output with overrun detection.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam logic [SW-1:0] SMP_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   p_bad_q, p_bad_d, f_bad_q, f_bad_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic rxs, tick, sampling, maj_pt, end_pt, maj, par_xor, last_stop, complete, load;

    assign rxs       = sync_q[1];
    assign tick      = (div_cnt_q == DW'(DIV - 1));
    assign sampling  = tick && (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign maj_pt    = sampling && (samp_cnt_q == SMP_HI);
    assign end_pt    = sampling && (samp_cnt_q == SMP_END);
    // third vote is the live sample at the majority point
    assign maj       = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign par_xor   = ^{shift_q, maj};
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

    always_comb begin
        sync_d     = {sync_q[0], rxd};
        state_d    = state_q;
        div_cnt_d  = (state_q == S_IDLE || tick) ? '0 : div_cnt_q + 1'b1;
        samp_cnt_d = sampling ? ((samp_cnt_q == SMP_END) ? '0 : samp_cnt_q + 1'b1) : samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        s0_d       = (sampling && samp_cnt_q == SMP_LO) ? rxs : s0_q;
        s1_d       = (sampling && samp_cnt_q == SMP_MID) ? rxs : s1_q;
        shift_d    = shift_q;
        p_bad_d    = p_bad_q;
        f_bad_d    = f_bad_q;
        complete   = 1'b0;
        case (state_q)
            S_IDLE: begin
                samp_cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                    p_bad_d = 1'b0;
                    f_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (maj_pt && maj) begin
                    state_d = S_IDLE;
                end else if (end_pt) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (maj_pt) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (end_pt) begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (maj_pt) p_bad_d = (PARITY == 2) ? par_xor : ~par_xor;
                if (end_pt) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (maj_pt && !maj) f_bad_d = 1'b1;
                // frame ends at the final stop bit's vote so back-to-back frames are not missed
                if (maj_pt && last_stop) begin
                    complete = 1'b1;
                    state_d  = (f_bad_q || !maj) ? S_WAIT_HIGH : S_IDLE;
                end else if (end_pt) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        load         = complete && (!rx_valid_q || rx_ready);
        rx_valid_d   = complete ? 1'b1 : (rx_valid_q && !rx_ready);
        rx_data_d    = load ? shift_q : rx_data_q;
        parity_err_d = load ? p_bad_q : parity_err_q;
        frame_err_d  = load ? f_bad_d : frame_err_q;
        overrun_d    = complete && !load;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            shift_q      <= '0;
            p_bad_q      <= 1'b0;
            f_bad_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shift_q      <= shift_d;
            p_bad_q      <= p_bad_d;
            f_bad_q      <= f_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg with an 8N1 and a 7E2 instance
// (16 clocks per bit); expected frames are queued by stimulus and checked on handshake.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd8 = 1'b1, rdy8 = 1'b0;
    logic [7:0] d8;
    logic       v8, pe8, fe8, ov8, bz8;
    logic       rxd7 = 1'b1, rdy7 = 1'b0;
    logic [6:0] d7;
    logic       v7, pe7, fe7, ov7, bz7;
    int         n_pass = 0, n_total = 0, ov_cnt8 = 0, ov_base = 0;
    logic [9:0] q8[$];
    logic [8:0] q7[$];
    logic [9:0] e8;
    logic [8:0] e7;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
        .clk(clk), .reset(reset), .rxd(rxd8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
        .parity_err(pe8), .frame_err(fe8), .overrun(ov8), .busy(bz8));

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
        .clk(clk), .reset(reset), .rxd(rxd7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
        .parity_err(pe7), .frame_err(fe7), .overrun(ov7), .busy(bz7));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (v8 && rdy8) begin
            chk("frame8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("frame8", 32'({fe8, pe8, d8}), 32'(e8));
            end
        end
        if (v7 && rdy7) begin
            chk("frame7_expected", 32'(q7.size() != 0), 32'd1);
            if (q7.size() != 0) begin
                e7 = q7.pop_front();
                chk("frame7", 32'({fe7, pe7, d7}), 32'(e7));
            end
        end
        if (ov8) ov_cnt8++;
    end

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7(input logic [6:0] d, input logic p, input logic s1, input logic s2);
        return {5'b0, s2, s1, p, d, 1'b0};
    endfunction

    task automatic set_line(input bit sel, input logic v);
        if (sel) rxd7 = v;
        else rxd8 = v;
    endtask

    // bit i spans posedges 16i..16i+16 after the first edge; gbit flips one clock inside that bit
    task automatic drive(input bit sel, input logic [15:0] bits, input int n, input int gbit);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 16; c++) begin
                set_line(sel, (i == gbit && c == 9) ? ~bits[i] : bits[i]);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept8;
        @(posedge clk);
        #1 rdy8 = 1'b1;
        @(posedge clk);
        #1 rdy8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("rst_valid8", 32'(v8), 0);
        chk("rst_busy8", 32'(bz8), 0);
        chk("rst_data8", 32'(d8), 0);
        chk("rst_flags8", 32'({pe8, fe8, ov8}), 0);
        chk("rst_out7", 32'({v7, bz7, d7, pe7, fe7, ov7}), 0);
        reset = 1'b1;
        idle(5);
        // 8N1 0xA5 held until accepted; valid rises exactly on edge 157 after the start edge
        q8.push_back(10'h0A5);
        fork
            drive(1'b0, f8(8'hA5, 1'b1), 10, -1);
            begin
                repeat (157) @(posedge clk);
                #1 chk("t1_early", 32'(v8), 0);
                @(posedge clk);
                #1 chk("t1_latency", 32'(v8), 1);
            end
        join
        idle(10);
        chk("t1_hold", 32'(v8), 1);
        chk("t1_data", 32'(d8), 32'hA5);
        accept8;
        chk("t1_clear", 32'(v8), 0);
        chk("t1_q_empty", 32'(q8.size()), 0);
        // 7E2 parity and second-stop-bit framing
        rdy7 = 1'b1;
        q7.push_back({1'b0, 1'b1, 7'h3C});
        drive(1'b1, f7(7'h3C, 1'b1, 1'b1, 1'b1), 11, -1);
        q7.push_back({1'b0, 1'b0, 7'h3C});
        drive(1'b1, f7(7'h3C, 1'b0, 1'b1, 1'b1), 11, -1);
        q7.push_back({1'b1, 1'b0, 7'h2A});
        drive(1'b1, f7(7'h2A, 1'b1, 1'b1, 1'b0), 11, -1);
        rxd7 = 1'b1;
        idle(40);
        chk("t2_q_empty", 32'(q7.size()), 0);
        chk("t2_idle", 32'(bz7), 0);
        rdy7 = 1'b0;
        // break: stop bit 0 then line held low
        rdy8 = 1'b1;
        q8.push_back({1'b1, 1'b0, 8'h55});
        drive(1'b0, f8(8'h55, 1'b0), 10, -1);
        idle(48);
        chk("t3_busy_low", 32'(bz8), 1);
        rxd8 = 1'b1;
        idle(5);
        chk("t3_busy_release", 32'(bz8), 0);
        idle(40);
        chk("t3_q_empty", 32'(q8.size()), 0);
        // glitched start bit
        rxd8 = 1'b0;
        idle(4);
        chk("t4_glitch_busy", 32'(bz8), 1);
        rxd8 = 1'b1;
        idle(16);
        chk("t4_glitch_idle", 32'(bz8), 0);
        chk("t4_glitch_valid", 32'(v8), 0);
        // one flipped sample inside a data bit is outvoted
        q8.push_back(10'h0F0);
        drive(1'b0, f8(8'hF0, 1'b1), 10, 5);
        q8.push_back(10'h0F0);
        drive(1'b0, f8(8'hF0, 1'b1), 10, 1);
        idle(20);
        chk("t4_q_empty", 32'(q8.size()), 0);
        rdy8 = 1'b0;
        // overrun: second frame lost, one-clock pulse at its completion
        q8.push_back(10'h011);
        drive(1'b0, f8(8'h11, 1'b1), 10, -1);
        ov_base = ov_cnt8;
        fork
            drive(1'b0, f8(8'h22, 1'b1), 10, -1);
            begin
                repeat (158) @(posedge clk);
                #1 chk("t5_ovr_pulse", 32'(ov8), 1);
                @(posedge clk);
                #1 chk("t5_ovr_width", 32'(ov8), 0);
            end
        join
        idle(10);
        chk("t5_ovr_count", 32'(ov_cnt8 - ov_base), 1);
        chk("t5_ovr_hold", 32'(d8), 32'h11);
        accept8;
        chk("t5_clear", 32'(v8), 0);
        chk("t5_q_empty", 32'(q8.size()), 0);
        // accept on the completion cycle: new frame loads, no overrun
        q8.push_back(10'h011);
        q8.push_back(10'h022);
        drive(1'b0, f8(8'h11, 1'b1), 10, -1);
        ov_base = ov_cnt8;
        fork
            drive(1'b0, f8(8'h22, 1'b1), 10, -1);
            begin
                repeat (157) @(posedge clk);
                #1 rdy8 = 1'b1;
                @(posedge clk);
                #1 rdy8 = 1'b0;
            end
        join
        idle(10);
        chk("t5_coinc_ovr", 32'(ov_cnt8 - ov_base), 0);
        chk("t5_coinc_valid", 32'(v8), 1);
        chk("t5_coinc_data", 32'(d8), 32'h22);
        accept8;
        chk("t5b_q_empty", 32'(q8.size()), 0);
        // reset mid-frame clears a pending frame and the partial one
        drive(1'b0, f8(8'h77, 1'b1), 10, -1);
        idle(5);
        chk("t6_pre_valid", 32'(v8), 1);
        drive(1'b0, f8(8'hE0, 1'b1), 5, -1);
        idle(8);
        chk("t6_pre_busy", 32'(bz8), 1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        rxd8 = 1'b1;
        chk("t6_rst_valid", 32'(v8), 0);
        chk("t6_rst_busy", 32'(bz8), 0);
        chk("t6_rst_data", 32'(d8), 0);
        chk("t6_rst_flags", 32'({pe8, fe8, ov8}), 0);
        idle(5);
        rdy8 = 1'b1;
        q8.push_back(10'h0C3);
        drive(1'b0, f8(8'hC3, 1'b1), 10, -1);
        idle(30);
        chk("t6_q_empty", 32'(q8.size()), 0);
        chk("t6_idle", 32'(bz8), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
